// File: rtl/demux_1to4_buf_if.sv
// Bundle between one producer and the four consumer channels of demux_1to4_buf.
// Handshake rule for both sides: a transfer completes on a rising clk edge
// where valid and ready are both high; valid never waits for ready, and the
// offering side holds its payload stable while valid && !ready.
interface demux_1to4_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_select;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [2:0]       occupancy;

    // Producer and consumers together (testbench / surrounding datapath).
    modport master (
        output in_valid, in_data, in_select, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
        input  occupancy
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, in_select, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
        output occupancy
    );
endinterface

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer. Each channel has a one-entry holding register
// and a full flag, so a stalled consumer only blocks words addressed to it.
// A channel that is draining this cycle may be refilled in the same cycle,
// giving one word per cycle per channel.
module demux_1to4_buf #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    demux_1to4_buf_if.slave  bus
);
    logic [3:0]       full_q;
    logic [WIDTH-1:0] hold_q [4];
    logic             accept;
    logic [2:0]       occ;

    // Ready depends only on the addressed channel: empty, or being drained now.
    always_comb begin
        bus.in_ready = rst_n && (!full_q[bus.in_select] || bus.out_ready[bus.in_select]);
        accept       = bus.in_valid && bus.in_ready;
    end

    // Per-channel holding register and full flag; a refill wins over a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (bus.in_select == 2'(i))) begin
                    hold_q[i] <= bus.in_data;
                    full_q[i] <= 1'b1;
                end else if (full_q[i] && bus.out_ready[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy is a popcount of the registered full flags.
    always_comb begin
        occ = '0;
        for (int i = 0; i < 4; i++) begin
            occ = occ + {2'b00, full_q[i]};
        end
    end

    assign bus.out_valid = full_q;
    assign bus.out_data0 = hold_q[0];
    assign bus.out_data1 = hold_q[1];
    assign bus.out_data2 = hold_q[2];
    assign bus.out_data3 = hold_q[3];
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Testbench for demux_1to4_buf: directed scenarios plus a randomized run,
// all checked against a per-channel queue model of the buffered demux.
module tb_demux_1to4_buf;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;

    demux_1to4_buf_if #(.WIDTH(WIDTH)) ifc ();

    demux_1to4_buf #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of pending words per channel (depth 1 by rule)
    // and the last word written to each channel, which the output keeps showing.
    logic [WIDTH-1:0] chan_q [4][$];
    logic [WIDTH-1:0] last_data [4];

    // Producer protocol tracking: an offer that stalled must be repeated unchanged.
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic [1:0]       prev_sel;

    function automatic logic model_ready(input logic [1:0] s, input logic [3:0] ordy);
        return rst_n && ((chan_q[s].size() == 0) || ordy[s]);
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (chan_q[i].size() != 0);
        return v;
    endfunction

    function automatic logic [2:0] model_occ();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += chan_q[i].size();
        return 3'(n);
    endfunction

    function automatic logic [WIDTH-1:0] dut_data(input int i);
        case (i)
            0:       return ifc.out_data0;
            1:       return ifc.out_data1;
            2:       return ifc.out_data2;
            default: return ifc.out_data3;
        endcase
    endfunction

    // Driver: apply inputs away from the clock edge, then let them settle.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] data,
                         input logic [3:0] ordy);
        ifc.in_valid  = v;
        ifc.in_select = sel;
        ifc.in_data   = data;
        ifc.out_ready = ordy;
        if (prev_stall && v) begin
            chk_cnt++;
            if (data !== prev_data || sel !== prev_sel)
                $display("FAIL producer_hold: got sel=%0d data=%h required sel=%0d data=%h",
                         sel, data, prev_sel, prev_data);
            else
                pass_cnt++;
        end
        #1;
    endtask

    // One clock edge: update the model from the values present at the edge,
    // then return on the falling edge where outputs are sampled.
    task automatic tick();
        prev_stall = rst_n && ifc.in_valid && !ifc.in_ready;
        prev_data  = ifc.in_data;
        prev_sel   = ifc.in_select;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                chan_q[i].delete();
                last_data[i] = '0;
            end
        end else begin
            logic acc;
            acc = ifc.in_valid && model_ready(ifc.in_select, ifc.out_ready);
            for (int i = 0; i < 4; i++)
                if (chan_q[i].size() != 0 && ifc.out_ready[i]) void'(chan_q[i].pop_front());
            if (acc) begin
                chan_q[ifc.in_select].push_back(ifc.in_data);
                last_data[ifc.in_select] = ifc.in_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'b0000);
        tick();
        tick();
        chk_cnt++;
        if (ifc.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", ifc.in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.out_valid !== 4'b0000) $display("FAIL reset_out_valid: got %b required 0000", ifc.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.occupancy !== 3'd0) $display("FAIL reset_occupancy: got %0d required 0", ifc.occupancy);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (dut_data(i) !== '0) $display("FAIL reset_out_data%0d: got %h required 0", i, dut_data(i));
            else pass_cnt++;
        end
        // First cycle out of reset: a single route to channel 2.
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        chk_cnt++;
        if (ifc.in_ready !== 1'b1) $display("FAIL route_in_ready: got %b required 1", ifc.in_ready);
        else pass_cnt++;
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk_cnt++;
        if (ifc.out_valid !== 4'b0100) $display("FAIL route_out_valid: got %b required 0100", ifc.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.out_data2 !== 32'hDEADBEEF) $display("FAIL route_out_data2: got %h required deadbeef", ifc.out_data2);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.occupancy !== 3'd1) $display("FAIL route_occupancy: got %0d required 1", ifc.occupancy);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 2'd1, 32'hCAFE0001, 4'b0000);
        tick();
        drive(1'b1, 2'd1, 32'h11111111, 4'b0000);
        chk_cnt++;
        if (ifc.in_ready !== 1'b0) $display("FAIL bp_stalled_ready: got %b required 0", ifc.in_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (ifc.out_data1 !== 32'hCAFE0001) $display("FAIL bp_hold_data1: got %h required cafe0001", ifc.out_data1);
        else pass_cnt++;
        drive(1'b1, 2'd1, 32'h11111111, 4'b0010);
        chk_cnt++;
        if (ifc.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", ifc.in_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (ifc.out_data1 !== 32'h11111111) $display("FAIL bp_new_data1: got %h required 11111111", ifc.out_data1);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.out_valid[1] !== 1'b1) $display("FAIL bp_valid1: got %b required 1", ifc.out_valid[1]);
        else pass_cnt++;
        drive(1'b0, 2'd0, '0, 4'b1111);
        tick();
        chk_cnt++;
        if (ifc.out_valid !== 4'b0000) $display("FAIL bp_drain_valid: got %b required 0000", ifc.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd3, 32'(k), 4'b1000);
            chk_cnt++;
            if (ifc.in_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b required 1", k, ifc.in_ready);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (ifc.out_valid[3] !== 1'b1 || ifc.out_data3 !== 32'(k))
                $display("FAIL stream_word_%0d: got valid=%b data=%h required valid=1 data=%h",
                         k, ifc.out_valid[3], ifc.out_data3, 32'(k));
            else pass_cnt++;
        end
        drive(1'b0, 2'd0, '0, 4'b1000);
        tick();
        chk_cnt++;
        if (ifc.occupancy !== 3'd0) $display("FAIL stream_end_occ: got %0d required 0", ifc.occupancy);
        else pass_cnt++;
    endtask

    task automatic test_fill_all();
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), $urandom, 4'b0000);
            tick();
            chk_cnt++;
            if (ifc.occupancy !== 3'(s + 1)) $display("FAIL fill_occ_%0d: got %0d required %0d", s, ifc.occupancy, s + 1);
            else pass_cnt++;
        end
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 32'h55555555, 4'b0000);
            chk_cnt++;
            if (ifc.in_ready !== 1'b0) $display("FAIL fill_full_ready_%0d: got %b required 0", s, ifc.in_ready);
            else pass_cnt++;
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        tick();
        chk_cnt++;
        if (ifc.occupancy !== 3'd0) $display("FAIL fill_drain_occ: got %0d required 0", ifc.occupancy);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 2'd0, 32'h0000AAAA, 4'b0000);
        tick();
        drive(1'b1, 2'd2, 32'h0000BBBB, 4'b0000);
        tick();
        drive(1'b1, 2'd2, 32'hA5A5A5A5, 4'b0101);
        chk_cnt++;
        if (ifc.in_ready !== 1'b1) $display("FAIL simul_ready: got %b required 1", ifc.in_ready);
        else pass_cnt++;
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk_cnt++;
        if (ifc.out_valid !== 4'b0100) $display("FAIL simul_valid: got %b required 0100", ifc.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.out_data2 !== 32'hA5A5A5A5) $display("FAIL simul_data2: got %h required a5a5a5a5", ifc.out_data2);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.occupancy !== 3'd1) $display("FAIL simul_occ: got %0d required 1", ifc.occupancy);
        else pass_cnt++;
        drive(1'b0, 2'd0, '0, 4'b1111);
        tick();
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'(s), 32'h77000000 | 32'(s), 4'b0000);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b1, 2'd3, 32'h99999999, 4'b1111);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk_cnt++;
        if (ifc.out_valid !== 4'b0000) $display("FAIL rstmid_valid: got %b required 0000", ifc.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (ifc.occupancy !== 3'd0) $display("FAIL rstmid_occ: got %0d required 0", ifc.occupancy);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (dut_data(i) !== '0) $display("FAIL rstmid_data%0d: got %h required 0", i, dut_data(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic             v;
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic [3:0]       ordy;
        v = 1'b0; sel = '0; data = '0;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!prev_stall) begin
                v    = ($urandom_range(0, 3) != 0);
                sel  = 2'($urandom_range(0, 3));
                data = $urandom;
            end
            ordy = 4'($urandom_range(0, 15));
            drive(v, sel, data, ordy);
            chk_cnt++;
            if (ifc.in_ready !== model_ready(sel, ordy))
                $display("FAIL rand_ready_%0d: got %b required %b", n, ifc.in_ready, model_ready(sel, ordy));
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (ifc.out_valid !== model_valid() || ifc.occupancy !== model_occ())
                $display("FAIL rand_state_%0d: got valid=%b occ=%0d required valid=%b occ=%0d",
                         n, ifc.out_valid, ifc.occupancy, model_valid(), model_occ());
            else pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                logic [WIDTH-1:0] e;
                e = (chan_q[i].size() != 0) ? chan_q[i][0] : last_data[i];
                chk_cnt++;
                if (dut_data(i) !== e) $display("FAIL rand_data%0d_%0d: got %h required %h", i, n, dut_data(i), e);
                else pass_cnt++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        chk_cnt    = 0;
        pass_cnt   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_sel   = '0;
        rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) last_data[i] = '0;
        @(negedge clk);
        test_reset();
        test_back_pressure();
        test_streaming();
        test_fill_all();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
